// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the digit-entry game datapath
package game_pkg;
    localparam int DIGIT_W = 4;
    localparam int NUM_DIGITS_DEF = 4;
    typedef enum logic [1:0] {IDLE, CLEAR, ENTRY, DONE} state_t;
endpackage

// File: rtl/digit_entry_sequencer.sv
// digit_entry_sequencer: steers entered switch digits into a bank of per-digit load registers
module digit_entry_sequencer
    import game_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int IDX_W = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  enter,
    input  logic                  backspace,
    input  logic [DIGIT_W-1:0]    sw_in,
    output logic [NUM_DIGITS-1:0] load_en,
    output logic [DIGIT_W-1:0]    load_data,
    output logic [IDX_W-1:0]      digit_idx,
    output logic [NUM_DIGITS-1:0] digit_valid,
    output logic                  busy,
    output logic                  entry_done
);
    function automatic logic [NUM_DIGITS-1:0] onehot(input logic [IDX_W-1:0] i);
        return NUM_DIGITS'(1) << i;
    endfunction

    state_t state, state_nx;
    logic do_clear, do_enter, do_back, last;
    logic [IDX_W-1:0] idx_prev;
    logic [NUM_DIGITS-1:0] load_en_nx, digit_valid_nx;
    logic [DIGIT_W-1:0] load_data_nx;
    logic [IDX_W-1:0] digit_idx_nx;
    logic busy_nx, entry_done_nx;

    // start outranks enter, which outranks backspace; CLEAR ignores everything
    always_comb begin
        do_clear = start && state != CLEAR;
        do_enter = state == ENTRY && !start && enter;
        do_back = state == ENTRY && !start && !enter && backspace && digit_idx != '0;
        last = digit_idx == IDX_W'(NUM_DIGITS - 1);
        idx_prev = digit_idx - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            load_en <= '0;
            load_data <= '0;
            digit_idx <= '0;
            digit_valid <= '0;
            busy <= 1'b0;
            entry_done <= 1'b0;
        end else begin
            state <= state_nx;
            load_en <= load_en_nx;
            load_data <= load_data_nx;
            digit_idx <= digit_idx_nx;
            digit_valid <= digit_valid_nx;
            busy <= busy_nx;
            entry_done <= entry_done_nx;
        end
    end

    always_comb begin
        state_nx = do_clear ? CLEAR :
                   state == CLEAR ? ENTRY :
                   (do_enter && last) ? DONE : state;
    end

    always_comb begin
        load_en_nx = do_clear ? '1 :
                     do_enter ? onehot(digit_idx) :
                     do_back ? onehot(idx_prev) : '0;
        load_data_nx = do_enter ? sw_in : '0;
        digit_idx_nx = do_clear ? '0 :
                       do_enter ? (last ? digit_idx : digit_idx + 1'b1) :
                       do_back ? idx_prev : digit_idx;
        digit_valid_nx = do_clear ? '0 :
                         do_enter ? (digit_valid | onehot(digit_idx)) :
                         do_back ? (digit_valid & ~onehot(idx_prev)) : digit_valid;
        busy_nx = state_nx == CLEAR || state_nx == ENTRY;
        entry_done_nx = state_nx == DONE;
    end
endmodule
